load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter BITS, default 32, data and address width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  core request present.
REQ-005 SHALL have port req_ready  out  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_we  in  1  0: load, 1: store.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  in  1  zero-extend load data when 1; sign-extend when 0.
REQ-009 SHALL have port req_addr  in  BITS  byte address.
REQ-010 SHALL have port req_wdata  in  BITS  store data, right-justified.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  BITS  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  misaligned or reserved-size request; valid with resp_valid.
REQ-014 SHALL have port mem_wen  out  1  word-memory write enable.
REQ-015 SHALL have port mem_a  out  BITS  word address; bits [1:0] always 0.
REQ-016 SHALL have port mem_d  out  BITS  word write data.
REQ-017 SHALL have port mem_q  in  BITS  word read data, combinational from mem_a in the same cycle.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, RESP.
REQ-019 SHALL drive req_ready high only in IDLE with rst low; a request is accepted when req_valid and req_ready are both high.
REQ-020 SHALL register we, size, unsigned, addr and wdata on acceptance; later changes on the req_* inputs SHALL be ignored until the next acceptance.
REQ-021 SHALL use these transitions from IDLE on acceptance: error goes to RESP; load goes to RD; word store goes to WR; byte or half store goes to RD.
REQ-022 SHALL use these transitions from the other states: RD goes to RESP for a load and to WR for a store; WR goes to RESP; RESP goes to IDLE.
REQ-023 SHALL flag an error when size is 11, when size is half and addr[0] is 1, or when size is word and addr[1:0] is not 00; an error SHALL perform no memory access.
REQ-024 SHALL, in RD, drive mem_a with {addr[31:2],2'b00} and mem_wen 0, and capture mem_q at the end of the cycle.
REQ-025 SHALL, in WR, drive mem_a with the aligned address and mem_wen 1, and drive mem_d with wdata for a word store, or with the captured word with the addressed lane replaced for a sub-word store.
REQ-026 SHALL use little-endian lane order: byte lane k = bits [8k+7:8k], k = addr[1:0]; half lane = addr[1].
REQ-027 SHALL assert resp_valid for exactly one cycle in RESP; there is no response backpressure.
REQ-028 SHALL meet these latencies for acceptance at edge N: error responds in cycle N+1; load and word store in N+2; sub-word store in N+3.
REQ-029 SHALL hold mem_wen at 0 in every state except WR, and at 0 whenever rst is high.
REQ-030 SHALL drive mem_a and mem_d to 0 in IDLE and RESP.

Reset
REQ-031 SHALL, while rst is high at a rising edge, set the state to IDLE from any state, and set resp_valid 0, resp_err 0, resp_rdata 0, and all captured registers 0.
REQ-032 SHALL drop any in-flight operation when rst is asserted mid-operation: no memory write and no response for it.
REQ-033 SHALL raise req_ready in the first cycle after rst goes low.

Structure
REQ-034 SHALL place the size encodings, the FSM state encoding and BITS in shared package lsu_pkg.
REQ-035 SHALL place lane extraction/extension and lane merge in one combinational sub-module lsu_align; the top holds the FSM and registers.

Verification (memory word at 0x100 preloaded with 0x8081_82F3)
REQ-036 SHALL check: load byte signed, addr 0x103 -> resp_rdata 0xFFFF_FF80 at N+2, mem_wen never high.
REQ-037 SHALL check: load half unsigned, addr 0x102 -> resp_rdata 0x0000_8081 at N+2.
REQ-038 SHALL check: store byte wdata 0x0000_005A, addr 0x101 -> mem_wen high only in N+2 with mem_d 0x8081_5AF3; resp_valid at N+3; a following word load of 0x100 returns 0x8081_5AF3.
REQ-039 SHALL check: load word, addr 0x102 -> resp_err 1 and resp_rdata 0 at N+1, with no memory access.
REQ-040 SHALL check: store word 0xDEAD_BEEF to 0x100 with rst asserted during WR -> word at 0x100 unchanged, no resp_valid, req_ready high the cycle after rst falls.
REQ-041 SHALL check: back-to-back requests with req_valid held high -> exactly one acceptance per IDLE visit, and req_ready low in RD, WR and RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access-size encodings,
// FSM state encoding, datapath width and the alignment-error rule.
package lsu_pkg;

    localparam int BITS = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // True when the request must be rejected without touching memory.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        unique case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: extracts and extends a load lane from
// a memory word, and merges a sub-word store into a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            load_unsigned,
    input  logic [1:0]      addr_lo,
    input  logic [BITS-1:0] load_word,
    input  logic [BITS-1:0] merge_word,
    input  logic [BITS-1:0] store_data,
    output logic [BITS-1:0] load_data,
    output logic [BITS-1:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        fill_bit;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        byte_lane = load_word[{addr_lo, 3'b000} +: 8];
        half_lane = load_word[{addr_lo[1], 4'b0000} +: 16];
        fill_bit  = 1'b0;
        load_data = '0;
        unique case (size_e'(size))
            SIZE_BYTE: begin
                fill_bit  = ~load_unsigned & byte_lane[7];
                load_data = {{24{fill_bit}}, byte_lane};
            end
            SIZE_HALF: begin
                fill_bit  = ~load_unsigned & half_lane[15];
                load_data = {{16{fill_bit}}, half_lane};
            end
            SIZE_WORD: load_data = load_word;
            default:   load_data = '0;
        endcase
    end

    // Sub-word stores rewrite only the addressed lane of the captured word.
    always_comb begin
        store_word = merge_word;
        unique case (size_e'(size))
            SIZE_BYTE: store_word[{addr_lo, 3'b000} +: 8]     = store_data[7:0];
            SIZE_HALF: store_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            SIZE_WORD: store_word = store_data;
            default:   store_word = merge_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, performs a word read
// and/or write on a combinational-read word memory, and returns a response.
module load_store_unit #(
    parameter int BITS = lsu_pkg::BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [BITS-1:0] req_addr,
    input  logic [BITS-1:0] req_wdata,
    output logic            resp_valid,
    output logic [BITS-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_wen,
    output logic [BITS-1:0] mem_a,
    output logic [BITS-1:0] mem_d,
    input  logic [BITS-1:0] mem_q
);
    import lsu_pkg::*;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    size_e           size_q, size_d;
    logic            uns_q, uns_d;
    logic [BITS-1:0] addr_q, addr_d;
    logic [BITS-1:0] wdata_q, wdata_d;
    logic [BITS-1:0] word_q, word_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [BITS-1:0] resp_rdata_q, resp_rdata_d;

    logic            accept;
    logic            req_bad;
    logic [BITS-1:0] aligned_addr;
    logic [BITS-1:0] load_data;
    logic [BITS-1:0] store_word;

    assign req_ready    = (state_q == IDLE) && !rst;
    assign accept       = req_valid && req_ready;
    assign req_bad      = is_misaligned(size_e'(req_size), req_addr[1:0]);
    assign aligned_addr = {addr_q[BITS-1:2], 2'b00};

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    lsu_align u_align (
        .size          (size_q),
        .load_unsigned (uns_q),
        .addr_lo       (addr_q[1:0]),
        .load_word     (mem_q),
        .merge_word    (word_q),
        .store_data    (wdata_q),
        .load_data     (load_data),
        .store_word    (store_word)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_wen      = 1'b0;
        mem_a        = '0;
        mem_d        = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we && size_e'(req_size) == SIZE_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_a  = aligned_addr;
                word_d = mem_q;
                if (we_q) begin
                    state_d = WR;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            WR: begin
                // Gating by rst keeps an interrupted store from reaching memory.
                mem_wen      = !rst;
                mem_a        = aligned_addr;
                mem_d        = store_word;
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            word_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule
